// File: rtl/ica_assoc.sv
// Set-associative instruction cache with round-robin replacement and tagged memory responses.
// Define ICA_PREFETCH_EN to add next-line prefetch after every demand fill.
module ica_assoc #(
    parameter int REG_WIDTH = 32,
    parameter int N_SETS    = 4,
    parameter int N_WAYS    = 2,
    parameter int N_BYTES   = 16,
    parameter int VA_WIDTH  = 32,
    parameter int PA_WIDTH  = 32,
    parameter int ID_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VA_WIDTH-1:0]   i_va_addr,
    input  logic [PA_WIDTH-1:0]   i_pa_addr,
    input  logic                  i_flush,
    output logic                  o_miss,
    output logic [REG_WIDTH-1:0]  o_read_data,
    output logic                  o_busy,
    output logic                  o_mem_enable,
    output logic [PA_WIDTH-1:0]   o_mem_addr,
    output logic                  o_mem_ack,
    input  logic                  i_mem_enable,
    input  logic [N_BYTES*8-1:0]  i_mem_data,
    input  logic [ID_WIDTH-1:0]   i_mem_id_request,
    input  logic [ID_WIDTH-1:0]   i_mem_id_response,
    input  logic                  i_mem_in_use
);

    localparam int OFF_W  = $clog2(N_BYTES);
    localparam int SET_W  = (N_SETS > 1) ? $clog2(N_SETS) : 1;
    localparam int WAY_W  = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
    localparam int TAG_W  = PA_WIDTH - OFF_W;
    localparam int WOFF_W = (OFF_W > 2) ? OFF_W - 2 : 1;
    localparam int LINE_W = N_BYTES * 8;
    localparam logic [REG_WIDTH-1:0] NOP = REG_WIDTH'(32'h0000_0013);

`ifdef ICA_PREFETCH_EN
    localparam logic PF_EN = 1'b1;
`else
    localparam logic PF_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, REQUEST, PF_ISSUE, PF_WAIT} state_t;

    state_t              r_state;
    logic [ID_WIDTH-1:0] r_id;
    logic [TAG_W-1:0]    r_line;
    logic [SET_W-1:0]    r_set;
    logic                r_discard;
    logic [N_WAYS-1:0]   r_valid [N_SETS];
    logic [WAY_W-1:0]    r_rr    [N_SETS];
    logic [TAG_W-1:0]    r_tag   [N_SETS][N_WAYS];
    logic [LINE_W-1:0]   r_data  [N_SETS][N_WAYS];

    logic [SET_W-1:0]    w_set;
    logic [TAG_W-1:0]    w_tag;
    logic [WOFF_W-1:0]   w_woff;
    logic [N_WAYS-1:0]   w_hit_way;
    logic [N_WAYS-1:0]   w_pf_way;
    logic [LINE_W-1:0]   w_line;
    logic [31:0]         w_word;
    logic                w_hit;
    logic                w_pf_hit;
    logic                w_rsp_match;
    logic                w_fill;
    logic                w_unused;

    generate
        if (N_SETS > 1) begin : g_set
            assign w_set = i_va_addr[OFF_W+SET_W-1:OFF_W];
        end else begin : g_noset
            assign w_set = '0;
        end
        if (OFF_W > 2) begin : g_woff
            assign w_woff = i_va_addr[OFF_W-1:2];
        end else begin : g_nowoff
            assign w_woff = '0;
        end
    endgenerate

    assign w_tag    = i_pa_addr[PA_WIDTH-1:OFF_W];
    assign w_unused = ^{i_va_addr, i_pa_addr[OFF_W-1:0]};

    // Tag compare for the demand fetch and for the pending prefetch target.
    always_comb begin
        w_line = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            w_hit_way[w] = r_valid[w_set][w] && (r_tag[w_set][w] == w_tag);
            w_pf_way[w]  = r_valid[r_set][w] && (r_tag[r_set][w] == r_line);
            w_line       = w_line | ({LINE_W{w_hit_way[w]}} & r_data[w_set][w]);
        end
    end

    assign w_hit       = |w_hit_way;
    assign w_pf_hit    = |w_pf_way;
    assign w_word      = w_line[{w_woff, 5'd0} +: 32];
    assign o_miss      = !w_hit;
    assign o_read_data = w_hit ? REG_WIDTH'(w_word) : NOP;
    assign o_busy      = (r_state != IDLE);

    assign w_rsp_match = i_mem_enable && (i_mem_id_response == r_id) &&
                         ((r_state == REQUEST) || (r_state == PF_WAIT));
    // A flushed transaction still consumes its response but must not install it.
    assign w_fill      = w_rsp_match && !i_flush && !r_discard;
    assign o_mem_ack   = w_rsp_match && !rst;

    // Memory request address and enable per state.
    always_comb begin
        o_mem_enable = 1'b0;
        o_mem_addr   = {r_line, {OFF_W{1'b0}}};
        case (r_state)
            IDLE: begin
                o_mem_enable = !w_hit && !rst;
                o_mem_addr   = {w_tag, {OFF_W{1'b0}}};
            end
            PF_ISSUE: begin
                o_mem_enable = !w_pf_hit && w_hit && !rst;
            end
            default: begin
                o_mem_enable = 1'b0;
            end
        endcase
    end

    // Control FSM, valid bits and replacement pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_id      <= '0;
            r_line    <= '0;
            r_set     <= '0;
            r_discard <= 1'b0;
            for (int s = 0; s < N_SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            if (i_flush) begin
                for (int s = 0; s < N_SETS; s++) begin
                    r_valid[s] <= '0;
                    r_rr[s]    <= '0;
                end
            end else if (w_fill) begin
                r_valid[r_set][r_rr[r_set]] <= 1'b1;
                r_rr[r_set] <= (N_WAYS > 1) ? r_rr[r_set] + 1'b1 : '0;
            end

            case (r_state)
                IDLE: begin
                    if (!w_hit && !i_mem_in_use) begin
                        r_id      <= i_mem_id_request;
                        r_line    <= w_tag;
                        r_set     <= w_set;
                        r_discard <= 1'b0;
                        r_state   <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (w_rsp_match) begin
                        r_discard <= 1'b0;
                        if (PF_EN && !i_flush && !r_discard) begin
                            r_line  <= r_line + 1'b1;
                            r_set   <= r_set + 1'b1;
                            r_state <= PF_ISSUE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (i_flush) begin
                        r_discard <= 1'b1;
                    end
                end
                PF_ISSUE: begin
                    // A demand miss takes priority over the speculative line.
                    if (i_flush || !w_hit || w_pf_hit) begin
                        r_state <= IDLE;
                    end else if (!i_mem_in_use) begin
                        r_id      <= i_mem_id_request;
                        r_discard <= 1'b0;
                        r_state   <= PF_WAIT;
                    end
                end
                PF_WAIT: begin
                    if (w_rsp_match) begin
                        r_discard <= 1'b0;
                        r_state   <= IDLE;
                    end else if (i_flush) begin
                        r_discard <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Line and tag storage written into the victim way.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[r_set][r_rr[r_set]] <= i_mem_data;
            r_tag[r_set][r_rr[r_set]]  <= r_line;
        end
    end

endmodule

// File: tb/tb_ica_assoc.sv
// Self-checking bench for ica_assoc: lookup table, fill scoreboard and corner-case sequences.
module tb_ica_assoc;

    logic         clk;
    logic         rst;
    logic [31:0]  i_va_addr;
    logic [31:0]  i_pa_addr;
    logic         i_flush;
    logic         o_miss;
    logic [31:0]  o_read_data;
    logic         o_busy;
    logic         o_mem_enable;
    logic [31:0]  o_mem_addr;
    logic         o_mem_ack;
    logic         i_mem_enable;
    logic [127:0] i_mem_data;
    logic [3:0]   i_mem_id_request;
    logic [3:0]   i_mem_id_response;
    logic         i_mem_in_use;

    int n_chk;
    int n_fail;
    logic [31:0] sb_q[$];

    typedef struct {
        logic [31:0] addr;
        logic        exp_miss;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs[5];

    ica_assoc dut (
        .clk(clk), .rst(rst),
        .i_va_addr(i_va_addr), .i_pa_addr(i_pa_addr), .i_flush(i_flush),
        .o_miss(o_miss), .o_read_data(o_read_data), .o_busy(o_busy),
        .o_mem_enable(o_mem_enable), .o_mem_addr(o_mem_addr), .o_mem_ack(o_mem_ack),
        .i_mem_enable(i_mem_enable), .i_mem_data(i_mem_data),
        .i_mem_id_request(i_mem_id_request), .i_mem_id_response(i_mem_id_response),
        .i_mem_in_use(i_mem_in_use)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] d;
        for (int w = 0; w < 4; w++) begin
            d[w*32 +: 32] = 32'h5A00_0000 | {a[31:4], 4'h0} | 32'(w);
        end
        return d;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [127:0] d;
        d = line_of(a);
        return d[{a[3:2], 5'd0} +: 32];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic sb_check(input string nm, input logic [31:0] act);
        logic [31:0] e;
        if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %0h", nm, act);
        end else begin
            e = sb_q.pop_front();
            chk(nm, act, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic fetch(input logic [31:0] a);
        i_va_addr = a;
        i_pa_addr = a;
    endtask

    task automatic respond(input logic [3:0] id, input logic [31:0] a);
        i_mem_enable      = 1'b1;
        i_mem_id_response = id;
        i_mem_data        = line_of(a);
    endtask

    // Serves any next-line prefetch the design starts after a demand fill.
    task automatic drain_prefetch(input logic [31:0] a);
`ifdef ICA_PREFETCH_EN
        i_mem_id_request = 4'hE;
        step();
        if (o_busy) begin
            respond(4'hE, a + 32'h10);
            step();
            i_mem_enable = 1'b0;
        end
`else
        i_mem_enable = 1'b0;
`endif
    endtask

    task automatic fill(input logic [31:0] a, input logic [3:0] id);
        fetch(a);
        i_mem_id_request = id;
        i_mem_in_use     = 1'b0;
        #1;
        chk("fill_miss", 32'(o_miss), 32'd1);
        chk("fill_req_addr", o_mem_addr, {a[31:4], 4'h0});
        step();
        chk("fill_busy", 32'(o_busy), 32'd1);
        respond(id, a);
        #1;
        chk("fill_ack", 32'(o_mem_ack), 32'd1);
        sb_q.push_back(word_of(a));
        step();
        i_mem_enable = 1'b0;
        #1;
        chk("fill_hit", 32'(o_miss), 32'd0);
        sb_check("fill_data", o_read_data);
        drain_prefetch(a);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        i_flush = 1'b0;
        i_mem_enable = 1'b0;
        i_mem_data = '0;
        i_mem_id_request = 4'd0;
        i_mem_id_response = 4'd0;
        i_mem_in_use = 1'b1;
        fetch(32'h100);

        vecs[0] = '{addr: 32'h100, exp_miss: 1'b0, exp_data: 32'h5A00_0100};
        vecs[1] = '{addr: 32'h108, exp_miss: 1'b0, exp_data: 32'h5A00_0102};
        vecs[2] = '{addr: 32'h10C, exp_miss: 1'b0, exp_data: 32'h5A00_0103};
        vecs[3] = '{addr: 32'h200, exp_miss: 1'b1, exp_data: 32'h0000_0013};
        vecs[4] = '{addr: 32'h120, exp_miss: 1'b1, exp_data: 32'h0000_0013};

        #12;
        chk("rst_mem_enable", 32'(o_mem_enable), 32'd0);
        chk("rst_ack", 32'(o_mem_ack), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_read_nop", o_read_data, 32'h13);
        rst = 1'b0;
        #1;
        chk("cold_miss", 32'(o_miss), 32'd1);
        chk("cold_nop", o_read_data, 32'h13);
        chk("cold_mem_enable", 32'(o_mem_enable), 32'd1);
        chk("cold_mem_addr", o_mem_addr, 32'h100);

        // Bus held busy: no transaction may start.
        fetch(32'h104);
        i_mem_id_request = 4'd3;
        step();
        step();
        chk("in_use_stays_idle", 32'(o_busy), 32'd0);
        i_mem_in_use = 1'b0;
        step();
        chk("released_request", 32'(o_busy), 32'd1);
        i_mem_id_request = 4'd9;
        respond(4'd2, 32'h500);
        #1;
        chk("wrong_id_no_ack", 32'(o_mem_ack), 32'd0);
        step();
        chk("wrong_id_still_busy", 32'(o_busy), 32'd1);
        respond(4'd3, 32'h100);
        #1;
        chk("right_id_ack", 32'(o_mem_ack), 32'd1);
        sb_q.push_back(32'h5A00_0101);
        step();
        i_mem_enable = 1'b0;
        #1;
        chk("hit_after_fill", 32'(o_miss), 32'd0);
        sb_check("offset4_word", o_read_data);
        drain_prefetch(32'h100);

        i_mem_in_use = 1'b1;
        for (int k = 0; k < 5; k++) begin
            fetch(vecs[k].addr);
            #1;
            chk($sformatf("tbl_miss_%0h", vecs[k].addr), 32'(o_miss), 32'(vecs[k].exp_miss));
            chk($sformatf("tbl_data_%0h", vecs[k].addr), o_read_data, vecs[k].exp_data);
        end

        fetch(32'h100);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        #1;
        chk("flush_clears", 32'(o_miss), 32'd1);

        fill(32'h000, 4'd1);
        fill(32'h040, 4'd2);
        fill(32'h080, 4'd3);
        i_mem_in_use = 1'b1;
        fetch(32'h000);
        #1;
        chk("rr_evicted_000", 32'(o_miss), 32'd1);
        fetch(32'h040);
        #1;
        chk("rr_kept_040", 32'(o_miss), 32'd0);
        fetch(32'h080);
        #1;
        chk("rr_kept_080", 32'(o_miss), 32'd0);
        chk("rr_data_080", o_read_data, 32'h5A00_0080);

        // Flush while a request is outstanding.
        fetch(32'h200);
        i_mem_id_request = 4'd5;
        i_mem_in_use = 1'b0;
        step();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        respond(4'd5, 32'h200);
        #1;
        chk("flush_req_ack", 32'(o_mem_ack), 32'd1);
        i_mem_id_request = 4'd6;
        step();
        i_mem_enable = 1'b0;
        #1;
        chk("flush_req_idle", 32'(o_busy), 32'd0);
        chk("flush_req_no_hit", 32'(o_miss), 32'd1);

        // Flush and matching response in the same cycle.
        step();
        i_flush = 1'b1;
        respond(4'd6, 32'h200);
        #1;
        chk("same_cycle_ack", 32'(o_mem_ack), 32'd1);
        step();
        i_flush = 1'b0;
        i_mem_enable = 1'b0;
        i_mem_in_use = 1'b1;
        #1;
        chk("same_cycle_no_hit", 32'(o_miss), 32'd1);
        chk("same_cycle_idle", 32'(o_busy), 32'd0);

        // Reset abandons an outstanding request.
        i_mem_id_request = 4'd7;
        i_mem_in_use = 1'b0;
        step();
        chk("pre_rst_busy", 32'(o_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_idle", 32'(o_busy), 32'd0);
        chk("mid_rst_enable", 32'(o_mem_enable), 32'd0);
        rst = 1'b0;
        i_mem_in_use = 1'b1;
        respond(4'd7, 32'h200);
        #1;
        chk("stale_id_no_ack", 32'(o_mem_ack), 32'd0);
        step();
        i_mem_enable = 1'b0;
        #1;
        chk("stale_id_no_fill", 32'(o_miss), 32'd1);

`ifdef ICA_PREFETCH_EN
        fetch(32'h100);
        i_mem_id_request = 4'd1;
        i_mem_in_use = 1'b0;
        step();
        respond(4'd1, 32'h100);
        step();
        i_mem_enable = 1'b0;
        #1;
        chk("pf_addr", o_mem_addr, 32'h110);
        chk("pf_enable", 32'(o_mem_enable), 32'd1);
        i_mem_id_request = 4'd2;
        step();
        respond(4'd2, 32'h110);
        #1;
        chk("pf_ack", 32'(o_mem_ack), 32'd1);
        step();
        i_mem_enable = 1'b0;
        fetch(32'h110);
        #1;
        chk("pf_hit", 32'(o_miss), 32'd0);
        chk("pf_data", o_read_data, 32'h5A00_0110);
        chk("pf_idle", 32'(o_busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
